axi4_burst_read_master: RTL
===========================

// Module: axi4_burst_read_master
// PURPOSE
// - Parametrised AXI4/AXI3 read master. Takes one linear read command (start address + beat count),
//   splits it into INCR bursts and streams the returned data out with valid/ready.
// - Bursts never cross a 4 KB boundary and never exceed the protocol's maximum burst length.
// - Successor to the single-burst master: adds protocol mode, burst splitting, an error summary,
//   and an optional abort on error.
// - Sits between a DMA-style client and an AXI interconnect slave port.
// PARAMETERS
// - DATA_W      default 32    R data width; a power of 2, 8..1024
// - ADDR_W      default 32    AR address width; >= 13
// - ID_W        default 1     ARID width
// - ID_VAL      default 0     constant ARID value
// - CMD_LEN_W   default 16    width of cmd_beats
// - AXI3_MODE   default 0     0: max burst 256 beats (AXI4); 1: max burst 16 beats (AXI3, ARLEN[7:4]=0)
// PORTS
// - clk            in   1            clock; all logic is rising-edge
// - rst            in   1            synchronous, active-high reset
// - cmd_valid      in   1            command request
// - cmd_ready      out  1            high only in IDLE
// - cmd_addr       in   ADDR_W       start byte address; bits [log2(DATA_W/8)-1:0] are ignored (treated as 0)
// - cmd_beats      in   CMD_LEN_W    total beats; 0 completes immediately with no AXI traffic
// - out_valid      out  1            read-data beat valid
// - out_ready      in   1            client accepts the beat
// - out_data       out  DATA_W       read data
// - out_last       out  1            last beat of the whole command
// - done           out  1            1-cycle pulse: command finished
// - err_resp       out  2            worst RRESP of the command (OKAY < EXOKAY < SLVERR < DECERR); valid with done
// - err_no_rlast   out  1            RLAST missing or misplaced in some burst; valid with done
// - ar*            out  -            arid, araddr, arlen[7:0], arsize[2:0], arburst, arlock, arcache[3:0],
//                                    arprot[2:0], arqos[3:0], arregion[3:0], arvalid
// - arready        in   1            AR handshake
// - rid/rdata/rresp/rlast/rvalid in; rready out   R channel (rid is ignored)
// BEHAVIOUR
// - Reset: state=IDLE. Outputs: arvalid=0, rready=0, out_valid=0, done=0, err_*=0, araddr=0, arlen=0.
// - Fixed AR fields:
//   - arsize  = log2(DATA_W/8)
//   - arburst = INCR (2'b01)
//   - arcache = 0, arprot = 0, arqos = 0, arregion = 0, arlock = 0
//   - arid    = ID_VAL
// - FSM IDLE -> ADDR -> DATA -> (ADDR | DONE) -> IDLE:
//   - IDLE: cmd_ready=1. On cmd_valid, latch the address and remaining beats, clear err_*.
//     If cmd_beats==0 go to DONE, otherwise go to ADDR.
//   - ADDR: burst length n = min(remaining, MAX, beats left to the next 4 KB boundary),
//     where boundary beats = (4096 - addr[11:0]) >> arsize. araddr/arlen=n-1 are registered and arvalid=1.
//     arvalid holds with araddr/arlen stable until arready. On handshake go to DATA.
//   - DATA: rready=out_ready; out_valid=rvalid; out_data=rdata (combinational pass-through, 0 latency).
//     Each accepted beat decrements the burst and total counters. out_last=1 on the beat where total==1.
//     - Burst end = n-th accepted beat. If remaining>0, address += n<<arsize and go to ADDR; else go to DONE.
//     - Only one burst is outstanding; AR is never issued before the previous burst's last beat.
//   - DONE: done=1 for one cycle, err_* stable; next state IDLE.
// - Error checks per beat:
//   - err_resp = max(err_resp, rresp).
//   - err_no_rlast set if rlast=1 on beat k<n, or rlast=0 on beat n.
//   - The burst still ends after n beats regardless of rlast.
// - rvalid outside DATA is never accepted (rready=0).
// - Counters: the address counter is ADDR_W and wraps modulo 2^ADDR_W. The total counter is CMD_LEN_W.
// - rst asserted mid-command: immediate return to IDLE, all outputs to reset values, in-flight AXI beats dropped.
//   The bench must not reuse the slave without resetting it too.
// CONFIGURATION
// - AXI4_BURST_RD_ABORT_EN defined:
//   - On a beat with rresp[1]=1 (SLVERR/DECERR), the current burst is still drained.
//   - No further AR is issued and the FSM goes to DONE. out_last is then never asserted for that command.
// - AXI4_BURST_RD_ABORT_EN undefined: all bursts are issued regardless of errors; errors are only summarised.
// TESTING
// - AXI4, DATA_W=32, addr=0x0000_1000, beats=4 -> one AR: arlen=3, arsize=2, arburst=01; 4 beats out;
//   out_last on beat 4; done with err_resp=00, err_no_rlast=0.
// - AXI4, addr=0x0000_0FF0, beats=8 -> AR0 0x0FF0 arlen=3; AR1 0x1000 arlen=3 (4 KB split); 8 beats out, single out_last.
// - AXI3_MODE=1, addr=0, beats=40 -> ARs with arlen 15, 15, 7 at 0x00, 0x40, 0x80.
// - out_ready toggling 1-0-1 on each beat and arready held low 5 cycles -> rready follows out_ready;
//   araddr/arlen stable while arvalid; no beat lost or duplicated.
// - Beat 2 of a 4-beat burst has rresp=10 and rlast=1 on beat 3 -> err_resp=10, err_no_rlast=1 at done.
//   With AXI4_BURST_RD_ABORT_EN and beats=40 on AXI3: only the first AR is issued.
// - cmd_beats=0 -> no arvalid; done 2 cycles after cmd handshake. rst pulsed mid-burst -> arvalid=rready=0 next cycle, cmd_ready=1.

Source files
------------

// File: rtl/axi4_burst_read_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_read_master
// Purpose  : AXI4/AXI3 INCR read master. Splits one linear read command into
//            4 KB-safe bursts and streams the data out with valid/ready.
//            Define AXI4_BURST_RD_ABORT_EN to stop issuing bursts after a
//            SLVERR/DECERR response.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_read_master #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int          ID_W      = 1,
    parameter int unsigned ID_VAL    = 0,
    parameter int          CMD_LEN_W = 16,
    parameter int          AXI3_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    // command
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [ADDR_W-1:0]    cmd_addr_i,
    input  logic [CMD_LEN_W-1:0] cmd_beats_i,
    // data stream
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_W-1:0]    out_data_o,
    output logic                 out_last_o,
    // completion
    output logic                 done_o,
    output logic [1:0]           err_resp_o,
    output logic                 err_no_rlast_o,
    // AR channel
    output logic [ID_W-1:0]      arid_o,
    output logic [ADDR_W-1:0]    araddr_o,
    output logic [7:0]           arlen_o,
    output logic [2:0]           arsize_o,
    output logic [1:0]           arburst_o,
    output logic                 arlock_o,
    output logic [3:0]           arcache_o,
    output logic [2:0]           arprot_o,
    output logic [3:0]           arqos_o,
    output logic [3:0]           arregion_o,
    output logic                 arvalid_o,
    input  logic                 arready_i,
    // R channel
    input  logic [ID_W-1:0]      rid_i,
    input  logic [DATA_W-1:0]    rdata_i,
    input  logic [1:0]           rresp_i,
    input  logic                 rlast_i,
    input  logic                 rvalid_i,
    output logic                 rready_o
);

    localparam int SIZE      = $clog2(DATA_W / 8);
    localparam int MAX_BEATS = (AXI3_MODE != 0) ? 16 : 256;
    localparam int CW        = (CMD_LEN_W > 13) ? CMD_LEN_W : 13;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << SIZE) - ADDR_W'(1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    addr_q;     // start address of the current burst
    logic [CMD_LEN_W-1:0] rem_q;
    logic [8:0]           blen_q;
    logic [8:0]           bcnt_q;
    logic                 arvalid_q;
    logic [ADDR_W-1:0]    araddr_q;
    logic [7:0]           arlen_q;
    logic                 done_q;
    logic [1:0]           err_resp_q;
    logic                 err_no_rlast_q;

    logic                 w_in_data;
    logic                 w_beat;
    logic                 w_burst_end;
    logic                 w_abort;
    logic                 w_more;
    logic [ADDR_W-1:0]    w_next_addr;
    logic [ADDR_W-1:0]    w_src_addr;
    logic [CMD_LEN_W-1:0] w_rem_dec;
    logic [CMD_LEN_W-1:0] w_src_rem;
    logic [12:0]          w_bnd;
    logic [CW-1:0]        w_n_x;
    logic [8:0]           w_n;
    logic                 w_unused;

    assign w_in_data   = (state_q == S_DATA);
    assign w_beat      = w_in_data & rvalid_i & out_ready_i;
    assign w_burst_end = (bcnt_q == 9'd1);
    assign w_rem_dec   = rem_q - CMD_LEN_W'(1);
    assign w_next_addr = addr_q + (ADDR_W'(blen_q) << SIZE);

    // The next burst is sized from the command in IDLE and from the advanced
    // address / post-beat remainder when the current burst closes.
    assign w_src_addr = (state_q == S_IDLE) ? (cmd_addr_i & ALIGN_MASK) : w_next_addr;
    assign w_src_rem  = (state_q == S_IDLE) ? cmd_beats_i : w_rem_dec;
    assign w_bnd      = (13'd4096 - {1'b0, w_src_addr[11:0]}) >> SIZE;

    always_comb begin
        w_n_x = CW'(w_src_rem);
        if (CW'(w_bnd) < w_n_x) begin
            w_n_x = CW'(w_bnd);
        end
        if (CW'(MAX_BEATS) < w_n_x) begin
            w_n_x = CW'(MAX_BEATS);
        end
    end
    assign w_n = w_n_x[8:0];

`ifdef AXI4_BURST_RD_ABORT_EN
    logic abort_q;
    assign w_abort = abort_q | (rvalid_i & rresp_i[1]);
`else
    assign w_abort = 1'b0;
`endif

    assign w_more = (w_rem_dec != '0) & ~w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            rem_q          <= '0;
            blen_q         <= '0;
            bcnt_q         <= '0;
            arvalid_q      <= 1'b0;
            araddr_q       <= '0;
            arlen_q        <= '0;
            done_q         <= 1'b0;
            err_resp_q     <= 2'b00;
            err_no_rlast_q <= 1'b0;
`ifdef AXI4_BURST_RD_ABORT_EN
            abort_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q         <= w_src_addr;
                        rem_q          <= cmd_beats_i;
                        err_resp_q     <= 2'b00;
                        err_no_rlast_q <= 1'b0;
`ifdef AXI4_BURST_RD_ABORT_EN
                        abort_q        <= 1'b0;
`endif
                        if (cmd_beats_i == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q   <= S_ADDR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= w_src_addr;
                            arlen_q   <= 8'(w_n - 9'd1);
                            blen_q    <= w_n;
                        end
                    end
                end
                S_ADDR: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        bcnt_q    <= blen_q;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        rem_q  <= w_rem_dec;
                        bcnt_q <= bcnt_q - 9'd1;
                        if (rresp_i > err_resp_q) begin
                            err_resp_q <= rresp_i;
                        end
                        // The burst length is ours; RLAST is only audited.
                        if (rlast_i != w_burst_end) begin
                            err_no_rlast_q <= 1'b1;
                        end
`ifdef AXI4_BURST_RD_ABORT_EN
                        if (rresp_i[1]) begin
                            abort_q <= 1'b1;
                        end
`endif
                        if (w_burst_end) begin
                            if (w_more) begin
                                addr_q    <= w_next_addr;
                                state_q   <= S_ADDR;
                                arvalid_q <= 1'b1;
                                araddr_q  <= w_src_addr;
                                arlen_q   <= 8'(w_n - 9'd1);
                                blen_q    <= w_n;
                            end else begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o    = (state_q == S_IDLE);
    assign out_valid_o    = w_in_data & rvalid_i;
    assign out_data_o     = rdata_i;
    assign out_last_o     = w_in_data & rvalid_i & (rem_q == CMD_LEN_W'(1)) & ~w_abort;
    assign rready_o       = w_in_data & out_ready_i;
    assign done_o         = done_q;
    assign err_resp_o     = err_resp_q;
    assign err_no_rlast_o = err_no_rlast_q;

    assign arid_o     = ID_W'(ID_VAL);
    assign araddr_o   = araddr_q;
    assign arlen_o    = arlen_q;
    assign arsize_o   = 3'(SIZE);
    assign arburst_o  = 2'b01;
    assign arlock_o   = 1'b0;
    assign arcache_o  = 4'h0;
    assign arprot_o   = 3'h0;
    assign arqos_o    = 4'h0;
    assign arregion_o = 4'h0;
    assign arvalid_o  = arvalid_q;

    assign w_unused = &{1'b0, rid_i, w_n_x[CW-1:9]};

endmodule
`default_nettype wire
